multicycle_control_unit: RTL and testbench

Main controller for the multicycle MIPS datapath. It drives the ALU and consumes its result: it generates the ALU operand selects and ALUControl, and consumes ZeroFlag to resolve branches. It sequences each instruction through fetch, decode, execute, memory and writeback steps using a Moore FSM with an embedded ALU decoder. It sits between the instruction register (Opcode/Funct) and the datapath enables.

---
 rtl/multicycle_control_unit.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch, decode,
// execute, memory and writeback steps, with an embedded ALU decoder.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   Opcode     instr[31:26]
//   Funct      instr[5:0]
//   ZeroFlag   ALU zero flag, used to resolve beq
//   ALUControl ALU operation select
//   ALUSrcA    0=PC, 1=regA
//   ALUSrcB    00=regB, 01=4, 10=SignImm, 11=SignImm<<2
//   PCSrc      00=ALUResult, 01=ALUOut, 10=jump target
//   PCEn       PC write enable
//   IorD       memory address select, 0=PC, 1=ALUOut
//   MemWrite   memory write enable
//   IRWrite    instruction register enable
//   RegDst     0=rt, 1=rd
//   MemtoReg   0=ALUOut, 1=Data
//   RegWrite   register file write enable
//   State      current state (debug)
//
// state    | meaning
// ---------+------------------------------------------
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, precompute branch target
// MEMADR   | compute lw/sw address
// MEMREAD  | read data memory
// MEMWB    | write loaded data to rt
// MEMWRITE | write regB to data memory
// EXECUTE  | R-type ALU operation
// ALUWB    | write ALU result to rd
// BRANCH   | compare regs, PC <= target if equal
// ADDIEX   | regA + SignImm
// ADDIWB   | write addi result to rt
// JUMP     | PC <= jump target
// 12..15   | illegal, no enables, recover to FETCH

module multicycle_control_unit #(
  parameter int Op_Size          = 6,
  parameter int ALU_Decoder_Size = 3,
  parameter int State_Size       = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [Op_Size-1:0]          Opcode,
  input  logic [Op_Size-1:0]          Funct,
  input  logic                        ZeroFlag,
  output logic [ALU_Decoder_Size-1:0] ALUControl,
  output logic                        ALUSrcA,
  output logic [1:0]                  ALUSrcB,
  output logic [1:0]                  PCSrc,
  output logic                        PCEn,
  output logic                        IorD,
  output logic                        MemWrite,
  output logic                        IRWrite,
  output logic                        RegDst,
  output logic                        MemtoReg,
  output logic                        RegWrite,
  output logic [State_Size-1:0]       State
);

  typedef enum logic [State_Size-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [Op_Size-1:0] OP_LW    = 6'b100011;
  localparam logic [Op_Size-1:0] OP_SW    = 6'b101011;
  localparam logic [Op_Size-1:0] OP_RTYPE = 6'b000000;
  localparam logic [Op_Size-1:0] OP_BEQ   = 6'b000100;
  localparam logic [Op_Size-1:0] OP_ADDI  = 6'b001000;
  localparam logic [Op_Size-1:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_write, branch;
  logic       ir_write_raw, mem_write_raw, reg_write_raw;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      // Opcode is held in the IR for the whole instruction, so it is still valid here.
      MEMADR:  state_d = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD: state_d = MEMWB;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    alu_op        = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSrc         = 2'b00;
    IorD          = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    pc_write      = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    case (state_q)
      FETCH: begin
        ALUSrcB      = 2'b01;
        ir_write_raw = 1'b1;
        pc_write     = 1'b1;
      end
      DECODE:   ALUSrcB = 2'b11;
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMREAD:  IorD = 1'b1;
      MEMWB: begin
        MemtoReg      = 1'b1;
        reg_write_raw = 1'b1;
      end
      MEMWRITE: begin
        IorD          = 1'b1;
        mem_write_raw = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
      end
      ALUWB: begin
        RegDst        = 1'b1;
        reg_write_raw = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b01;
        PCSrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIWB:   reg_write_raw = 1'b1;
      JUMP: begin
        PCSrc    = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b010;
    case (alu_op)
      2'b01: ALUControl = 3'b100;
      2'b10: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b100;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b110;
          6'b011000: ALUControl = 3'b101;
          default:   ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // Strobes are masked by RST directly so a reset in any state suppresses
  // writes in that same cycle, not just from the next edge on.
  assign PCEn     = ~RST & (pc_write | (branch & ZeroFlag));
  assign IRWrite  = ~RST & ir_write_raw;
  assign MemWrite = ~RST & mem_write_raw;
  assign RegWrite = ~RST & reg_write_raw;
  assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  logic       CLK, RST, ZeroFlag;
  logic [5:0] Opcode, Funct;
  logic [2:0] ALUControl;
  logic       ALUSrcA, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  multicycle_control_unit dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .ZeroFlag(ZeroFlag),
    .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .State(State)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input logic [3:0] exp_state);
    @(posedge CLK);
    #1;
    check_val("state", {28'd0, State}, {28'd0, exp_state});
  endtask

  task automatic no_writes(input string tag);
    check_val({tag, "_strobes"}, {28'd0, IRWrite, PCEn, MemWrite, RegWrite}, 32'd0);
  endtask

  logic [5:0] funct_tab [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                6'b101010, 6'b011000, 6'b111111};
  logic [2:0] aluc_tab  [7] = '{3'b010, 3'b100, 3'b000, 3'b001,
                                3'b110, 3'b101, 3'b010};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; Opcode = 6'b0; Funct = 6'b0; ZeroFlag = 1'b0;

    // reset held for two cycles
    repeat (2) begin
      @(posedge CLK); #1;
      check_val("rst_state", {28'd0, State}, 32'd0);
      no_writes("rst");
    end
    RST = 1'b0; #1;
    check_val("fetch_ir", {31'd0, IRWrite}, 32'd1);
    check_val("fetch_pcen", {31'd0, PCEn}, 32'd1);
    check_val("fetch_srcb", {30'd0, ALUSrcB}, 32'd1);
    check_val("fetch_aluc", {29'd0, ALUControl}, 32'd2);

    // lw
    Opcode = 6'b100011;
    go(4'd1);
    check_val("dec_srcb", {30'd0, ALUSrcB}, 32'd3);
    no_writes("dec");
    go(4'd2);
    check_val("madr_src", {29'd0, ALUSrcA, ALUSrcB}, 32'b110);
    go(4'd3);
    check_val("mrd_iord", {31'd0, IorD}, 32'd1);
    no_writes("mrd");
    go(4'd4);
    check_val("mwb", {29'd0, RegWrite, MemtoReg, RegDst}, 32'b110);
    go(4'd0);

    // sw
    Opcode = 6'b101011;
    go(4'd1);
    check_val("sw_dec_mw", {31'd0, MemWrite}, 32'd0);
    go(4'd2);
    check_val("sw_madr_mw", {31'd0, MemWrite}, 32'd0);
    go(4'd5);
    check_val("mwr", {29'd0, MemWrite, IorD, RegWrite}, 32'b110);
    go(4'd0);
    check_val("sw_done_mw", {31'd0, MemWrite}, 32'd0);

    // R-type funct sweep
    Opcode = 6'b000000;
    for (int i = 0; i < 7; i++) begin
      Funct = funct_tab[i];
      go(4'd1);
      go(4'd6);
      check_val("ex_aluc", {29'd0, ALUControl}, {29'd0, aluc_tab[i]});
      check_val("ex_src", {29'd0, ALUSrcA, ALUSrcB}, 32'b100);
      go(4'd7);
      check_val("aluwb", {29'd0, RegDst, RegWrite, MemtoReg}, 32'b110);
      go(4'd0);
    end

    // beq taken, then ZeroFlag dropped inside BRANCH
    Opcode = 6'b000100; ZeroFlag = 1'b1;
    go(4'd1);
    go(4'd8);
    check_val("beq_pcen", {31'd0, PCEn}, 32'd1);
    check_val("beq_pcsrc", {30'd0, PCSrc}, 32'd1);
    check_val("beq_aluc", {29'd0, ALUControl}, 32'b100);
    ZeroFlag = 1'b0; #1;
    check_val("beq_pcen_comb", {31'd0, PCEn}, 32'd0);
    go(4'd0);
    // beq not taken
    go(4'd1);
    go(4'd8);
    check_val("bne_pcen", {31'd0, PCEn}, 32'd0);
    go(4'd0);

    // j
    Opcode = 6'b000010;
    go(4'd1);
    go(4'd11);
    check_val("j_pc", {29'd0, PCSrc, PCEn}, 32'b101);
    go(4'd0);

    // addi
    Opcode = 6'b001000;
    go(4'd1);
    go(4'd9);
    check_val("addi_src", {29'd0, ALUSrcA, ALUSrcB}, 32'b110);
    check_val("addi_aluc", {29'd0, ALUControl}, 32'b010);
    go(4'd10);
    check_val("addiwb", {29'd0, RegWrite, RegDst, MemtoReg}, 32'b100);
    go(4'd0);

    // unknown opcode
    Opcode = 6'b111111;
    go(4'd1);
    no_writes("nop");
    go(4'd0);

    // reset in MEMREAD abandons lw
    Opcode = 6'b100011;
    go(4'd1);
    go(4'd2);
    go(4'd3);
    RST = 1'b1; #1;
    no_writes("rst_mid");
    go(4'd0);
    no_writes("rst_mid2");
    RST = 1'b0; #1;
    check_val("resume_ir", {31'd0, IRWrite}, 32'd1);
    Opcode = 6'b000010;
    go(4'd1);
    go(4'd11);
    go(4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
